// File: rtl/iobus_arbiter.sv
// Two-master request/acknowledge arbiter serialising transactions onto the OTTER IOBUS.
// Define IOBUS_ARB_FIXED_PRI_EN for fixed priority (master 0 wins ties); default is round-robin.
module iobus_arbiter #(
  parameter logic [31:0] ADDR_BASE = 32'h11000000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFFFF00
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        M0_REQ,
  input  logic        M0_WR,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  output logic        M0_ACK,
  output logic [31:0] M0_RDATA,
  output logic        M0_ERR,
  input  logic        M1_REQ,
  input  logic        M1_WR,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  output logic        M1_ACK,
  output logic [31:0] M1_RDATA,
  output logic        M1_ERR,
  output logic [31:0] IOBUS_ADDR,
  output logic [31:0] IOBUS_OUT,
  output logic        IOBUS_WR,
  input  logic [31:0] IOBUS_IN
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [1:0]  state_r;
  logic        win_r;
  logic        wr_r;
  logic        legal_r;
  logic        grant_s;
  logic        any_req_s;
  logic        sel_wr_s;
  logic        sel_legal_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [31:0] rd_s;

`ifndef IOBUS_ARB_FIXED_PRI_EN
  logic        last_r;
`endif

  // Winner selection and request mux; a lone requester always wins.
  always_comb begin
    any_req_s = M0_REQ | M1_REQ;
    if (M0_REQ && M1_REQ) begin
`ifdef IOBUS_ARB_FIXED_PRI_EN
      grant_s = 1'b0;
`else
      grant_s = ~last_r;
`endif
    end else if (M1_REQ) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      sel_wr_s    = M1_WR;
      sel_addr_s  = M1_ADDR;
      sel_wdata_s = M1_WDATA;
    end else begin
      sel_wr_s    = M0_WR;
      sel_addr_s  = M0_ADDR;
      sel_wdata_s = M0_WDATA;
    end
    sel_legal_s = ((sel_addr_s & ADDR_MASK) == ADDR_BASE);
  end

  // Writes and illegal accesses return zero so stale bus data never leaks to a master.
  always_comb begin
    if (legal_r && !wr_r) begin
      rd_s = IOBUS_IN;
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

  // Transaction sequencer: IDLE latches the winner, ISSUE drives the bus, ACK completes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= S_IDLE;
      win_r      <= 1'b0;
      wr_r       <= 1'b0;
      legal_r    <= 1'b0;
      IOBUS_ADDR <= 32'h0000_0000;
      IOBUS_OUT  <= 32'h0000_0000;
      IOBUS_WR   <= 1'b0;
      M0_ACK     <= 1'b0;
      M1_ACK     <= 1'b0;
      M0_ERR     <= 1'b0;
      M1_ERR     <= 1'b0;
      M0_RDATA   <= 32'h0000_0000;
      M1_RDATA   <= 32'h0000_0000;
`ifndef IOBUS_ARB_FIXED_PRI_EN
      last_r     <= 1'b1;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (any_req_s) begin
            win_r      <= grant_s;
            wr_r       <= sel_wr_s;
            legal_r    <= sel_legal_s;
            IOBUS_ADDR <= sel_addr_s;
            IOBUS_OUT  <= sel_wdata_s;
            IOBUS_WR   <= sel_wr_s & sel_legal_s;
            state_r    <= S_ISSUE;
          end else begin
            state_r    <= S_IDLE;
          end
        end
        S_ISSUE: begin
          IOBUS_ADDR <= 32'h0000_0000;
          IOBUS_OUT  <= 32'h0000_0000;
          IOBUS_WR   <= 1'b0;
          if (win_r) begin
            M1_RDATA <= rd_s;
          end else begin
            M0_RDATA <= rd_s;
          end
          M0_ACK  <= ~win_r;
          M1_ACK  <= win_r;
          M0_ERR  <= ~win_r & ~legal_r;
          M1_ERR  <= win_r & ~legal_r;
          state_r <= S_ACK;
        end
        S_ACK: begin
          M0_ACK  <= 1'b0;
          M1_ACK  <= 1'b0;
          M0_ERR  <= 1'b0;
          M1_ERR  <= 1'b0;
`ifndef IOBUS_ARB_FIXED_PRI_EN
          last_r  <= win_r;
`endif
          state_r <= S_IDLE;
        end
        default: begin
          IOBUS_ADDR <= 32'h0000_0000;
          IOBUS_OUT  <= 32'h0000_0000;
          IOBUS_WR   <= 1'b0;
          M0_ACK     <= 1'b0;
          M1_ACK     <= 1'b0;
          M0_ERR     <= 1'b0;
          M1_ERR     <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_arbiter.sv
// Self-checking bench for iobus_arbiter: transaction-level reference model plus directed and random scenarios.
module tb_iobus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req, m1_req, m0_wr, m1_wr;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] iobus_addr, iobus_out, iobus_in;
  logic        iobus_wr;
  logic [132:0] obs;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          cyc = 0;
  int          idle_at = 0;
  int          last_m = 1;
  bit          p_valid = 1'b0;
  int          p_m = 0;
  int          p_k = 0;
  logic        p_wr = 1'b0;
  logic [31:0] p_addr = 32'h0;
  logic [31:0] p_data = 32'h0;
  logic [31:0] mrd [2];
  logic [1:0]  e_ack = 2'b00;
  logic [132:0] exp_v = '0;

  iobus_arbiter dut (
    .CLK(clk), .RST_N(rst_n),
    .M0_REQ(m0_req), .M0_WR(m0_wr), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
    .M0_ACK(m0_ack), .M0_RDATA(m0_rdata), .M0_ERR(m0_err),
    .M1_REQ(m1_req), .M1_WR(m1_wr), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
    .M1_ACK(m1_ack), .M1_RDATA(m1_rdata), .M1_ERR(m1_err),
    .IOBUS_ADDR(iobus_addr), .IOBUS_OUT(iobus_out), .IOBUS_WR(iobus_wr), .IOBUS_IN(iobus_in)
  );

  always #5 clk = ~clk;

  // peripheral model: switches read back as low address bits xor A5A5
  assign iobus_in = {16'h0000, iobus_addr[15:0] ^ 16'hA5A5};
  assign obs = {iobus_wr, iobus_addr, iobus_out, m0_ack, m0_err, m1_ack, m1_err, m0_rdata, m1_rdata};

  function automatic bit is_legal(input logic [31:0] a);
    return (a & 32'hFFFFFF00) == 32'h11000000;
  endfunction

  function automatic logic [31:0] bus_val(input logic [31:0] a);
    return {16'h0000, a[15:0] ^ 16'hA5A5};
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return $urandom();
    return 32'h11000000 | 32'($urandom_range(0, 255));
  endfunction

  task automatic drive(input int m, input logic req, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_req = req; m0_wr = wr; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = req; m1_wr = wr; m1_addr = a; m1_wdata = d;
    end
  endtask

  // Advance one clock; the model predicts what the arbiter must show in the following window.
  task automatic step();
    int k;
    int w;
    logic        e_wr;
    logic [31:0] e_addr, e_out;
    logic [1:0]  e_err;
    k = cyc + 1;
    if (!rst_n) begin
      p_valid = 1'b0; last_m = 1; mrd[0] = 32'h0; mrd[1] = 32'h0; idle_at = k;
    end else if (k >= idle_at && (m0_req || m1_req)) begin
      if (m0_req && m1_req) begin
`ifdef IOBUS_ARB_FIXED_PRI_EN
        w = 0;
`else
        w = 1 - last_m;
`endif
      end else begin
        w = m1_req ? 1 : 0;
      end
      p_valid = 1'b1; p_m = w; p_k = k; idle_at = k + 3; last_m = w;
      p_wr   = (w == 0) ? m0_wr : m1_wr;
      p_addr = (w == 0) ? m0_addr : m1_addr;
      p_data = (w == 0) ? m0_wdata : m1_wdata;
    end
    @(posedge clk);
    #1;
    cyc = k;
    e_wr = 1'b0; e_addr = 32'h0; e_out = 32'h0; e_ack = 2'b00; e_err = 2'b00;
    if (p_valid && k == p_k) begin
      e_wr = p_wr && is_legal(p_addr); e_addr = p_addr; e_out = p_data;
    end
    if (p_valid && k == p_k + 1) begin
      e_ack[p_m] = 1'b1;
      e_err[p_m] = !is_legal(p_addr);
      mrd[p_m] = (is_legal(p_addr) && !p_wr) ? bus_val(p_addr) : 32'h0;
    end
    exp_v = {e_wr, e_addr, e_out, e_ack[0], e_err[0], e_ack[1], e_err[1], mrd[0], mrd[1]};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bit found;
    do_reset();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_state got %h expected 0", obs);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL reset_idle got %h expected %h", obs, exp_v);
      end
    end
    drive(0, 1'b1, 1'b1, 32'h11000004, 32'h0000_1234);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (exp_v[132]) found = 1'b1;
    end
    checks++;
    if (!found || iobus_wr !== 1'b1) begin
      errors++; $display("FAIL reset_issue_wr got %b expected 1", iobus_wr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_async_clear got %h expected 0", obs);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL reset_release got %h expected %h", obs, exp_v);
      end
    end
  endtask

  task automatic test_single_write();
    int wr_k = -1, ack_k = -1, n_wr = 0;
    logic [31:0] wa = 32'h0, wd = 32'h0;
    drive(0, 1'b1, 1'b1, 32'h11000020, 32'h0000_BEEF);
    for (int i = 0; i < 8 && ack_k < 0; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL single_write_cycle got %h expected %h", obs, exp_v);
      end
      if (iobus_wr === 1'b1) begin n_wr++; wr_k = cyc; wa = iobus_addr; wd = iobus_out; end
      if (m0_ack === 1'b1) ack_k = cyc;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (ack_k < 0 || ack_k - wr_k != 1 || n_wr != 1 || wa !== 32'h11000020 || wd !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL single_write got wr=%0d ack_at=%0d wr_at=%0d addr=%h data=%h expected wr=1 ack one cycle after wr addr=11000020 data=0000beef",
               n_wr, ack_k, wr_k, wa, wd);
    end
    step();
  endtask

  task automatic test_single_read();
    int n_wr = 0;
    bit acked = 1'b0;
    logic [31:0] rd = 32'h0;
    drive(1, 1'b1, 1'b0, 32'h11000000, 32'h0);
    for (int i = 0; i < 8 && !acked; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL single_read_cycle got %h expected %h", obs, exp_v);
      end
      if (iobus_wr === 1'b1) n_wr++;
      if (m1_ack === 1'b1) begin acked = 1'b1; rd = m1_rdata; end
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (!acked || rd !== 32'h0000A5A5 || n_wr != 0) begin
      errors++; $display("FAIL single_read got ack=%b rdata=%h wr=%0d expected ack=1 rdata=0000a5a5 wr=0", acked, rd, n_wr);
    end
    step();
  endtask

  task automatic test_illegal();
    int n_wr = 0;
    bit acked = 1'b0;
    logic e = 1'b0;
    logic [31:0] rd = 32'hFFFF_FFFF;
    drive(0, 1'b1, 1'b1, 32'h1000_0000, 32'h0000_0055);
    for (int i = 0; i < 8 && !acked; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL illegal_cycle got %h expected %h", obs, exp_v);
      end
      if (iobus_wr === 1'b1) n_wr++;
      if (m0_ack === 1'b1) begin acked = 1'b1; e = m0_err; rd = m0_rdata; end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (!acked || e !== 1'b1 || rd !== 32'h0 || n_wr != 0) begin
      errors++; $display("FAIL illegal got ack=%b err=%b rdata=%h wr=%0d expected ack=1 err=1 rdata=0 wr=0", acked, e, rd, n_wr);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int wk[$];
    int n_ack = 0;
    logic [31:0] a2 = 32'h0;
    drive(1, 1'b1, 1'b1, 32'h11000030, 32'h0000_0001);
    for (int i = 0; i < 12 && n_ack < 2; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL b2b_cycle got %h expected %h", obs, exp_v);
      end
      if (iobus_wr === 1'b1) begin wk.push_back(cyc); a2 = iobus_addr; end
      if (e_ack[1]) begin
        n_ack++;
        if (n_ack == 1) drive(1, 1'b1, 1'b1, 32'h11000040, 32'h0000_0002);
        else drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    checks++;
    if (wk.size() != 2 || wk[1] - wk[0] != 3 || a2 !== 32'h11000040) begin
      errors++; $display("FAIL back_to_back got pulses=%0d gap=%0d addr=%h expected pulses=2 gap=3 addr=11000040",
                         wk.size(), (wk.size() == 2) ? wk[1] - wk[0] : -1, a2);
    end
    step();
  endtask

  task automatic test_contention();
    int order[$];
    int expo[8];
    int left[2];
    do_reset();
    left[0] = 4; left[1] = 4;
    drive(0, 1'b1, 1'b1, 32'h11000010, 32'h0000_0A00);
    drive(1, 1'b1, 1'b0, 32'h11000080, 32'h0);
    for (int i = 0; i < 60 && (left[0] > 0 || left[1] > 0); i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL contention_cycle got %h expected %h", obs, exp_v);
      end
      if (m0_ack === 1'b1) order.push_back(0);
      if (m1_ack === 1'b1) order.push_back(1);
      for (int m = 0; m < 2; m++) begin
        if (e_ack[m]) begin
          left[m]--;
          if (left[m] > 0) drive(m, 1'b1, (m == 0), 32'h11000010 + 32'(m * 112 + left[m]), 32'(left[m]));
          else drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
`ifdef IOBUS_ARB_FIXED_PRI_EN
      expo[i] = (i < 4) ? 0 : 1;
`else
      expo[i] = i % 2;
`endif
    end
    checks++;
    if (order.size() != 8) begin
      errors++; $display("FAIL contention_count got %0d expected 8", order.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (order[i] != expo[i]) begin
          errors++; $display("FAIL contention_order slot %0d got M%0d expected M%0d", i, order[i], expo[i]);
        end
      end
    end
    step();
  endtask

  task automatic test_random();
    bit pend[2];
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (e_ack[m]) pend[m] = 1'b0;
        if (!pend[m]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[m] = 1'b1;
            drive(m, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
          end else begin
            drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
          end
        end
      end
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL random_cycle %0d got %h expected %h", cyc, obs, exp_v);
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL random_drain got %h expected %h", obs, exp_v);
      end
    end
  endtask

  initial begin
    mrd[0] = 32'h0; mrd[1] = 32'h0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_single_write();
    test_single_read();
    test_illegal();
    test_back_to_back();
    test_contention();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
